// File: rtl/serial_borrow_down_counter.sv
// Down counter built from a serial borrow chain of toggle stages, with parallel load,
// zero detect, cascadable borrow-out and IDLE/RUN/DONE control. Optional macro: AUTO_RELOAD_EN.
module serial_borrow_down_counter_stage (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic d,
  input  logic t,
  output logic q
);
  logic q_reg;

  // Load beats toggle, so a reload on the same edge as a borrow never decrements.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      q_reg <= 1'b0;
    end else if (load) begin
      q_reg <= d;
    end else if (t) begin
      q_reg <= ~q_reg;
    end
  end

  assign q = q_reg;
endmodule

module serial_borrow_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             oneshot,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             borrow_out,
  output logic             done
);
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_reg;
  logic             done_reg;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] borrow_chain;
  logic             running;
  logic             count_step;
  logic             stop_at_zero;
  logic             auto_reload;
  logic             stage_load;
  logic             toggle_step;

  assign running    = (state_reg == ST_RUN);
  assign count_step = en & ~load & running;
  assign zero       = (count_q == '0);

  // In one-shot mode the zero edge moves the FSM to DONE and the bits must not wrap.
  assign stop_at_zero = count_step & zero & oneshot;

`ifdef AUTO_RELOAD_EN
  assign auto_reload = count_step & zero & ~oneshot;
`else
  assign auto_reload = 1'b0;
`endif

  assign stage_load  = load | auto_reload;
  assign toggle_step = count_step & ~stop_at_zero & ~auto_reload;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      // Bit i toggles only when every lower bit is already 0 (borrow ripples upward).
      if (gi == 0) begin : g_lsb
        assign borrow_chain[gi] = toggle_step;
      end else begin : g_upper
        assign borrow_chain[gi] = borrow_chain[gi-1] & ~count_q[gi-1];
      end

      serial_borrow_down_counter_stage u_stage (
        .clk   (clk),
        .reset (reset),
        .load  (stage_load),
        .d     (load_val[gi]),
        .t     (borrow_chain[gi]),
        .q     (count_q[gi])
      );
    end
  endgenerate

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (load) begin
            state_reg <= ST_RUN;
          end
          done_reg <= 1'b0;
        end
        ST_RUN: begin
          if (stop_at_zero) begin
            state_reg <= ST_DONE;
            done_reg  <= 1'b1;
          end else begin
            done_reg  <= 1'b0;
          end
        end
        ST_DONE: begin
          if (load) begin
            state_reg <= ST_RUN;
            done_reg  <= 1'b0;
          end else begin
            done_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign out        = count_q;
  assign borrow_out = count_step & zero;
  assign done       = done_reg;
endmodule

// File: tb/tb_serial_borrow_down_counter.sv
// Directed bench for serial_borrow_down_counter (WIDTH=4); expected values are hand-derived.
module tb_serial_borrow_down_counter;
  localparam int WIDTH = 4;

  logic             clk;
  logic             reset;
  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             oneshot;
  logic [WIDTH-1:0] out;
  logic             zero;
  logic             borrow_out;
  logic             done;

  int checks_total;
  int checks_passed;

  serial_borrow_down_counter #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .load       (load),
    .load_val   (load_val),
    .oneshot    (oneshot),
    .out        (out),
    .zero       (zero),
    .borrow_out (borrow_out),
    .done       (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) begin
      checks_passed++;
      $display("check %-24s got=%0d exp=%0d ok", tag, got, exp);
    end else begin
      $display("FAIL %-24s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance one active (falling) edge, then settle before sampling.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  int exp_seq [5];

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    reset    = 1'b1;
    en       = 1'b0;
    load     = 1'b0;
    load_val = '0;
    oneshot  = 1'b0;
    tick();
    tick();
    check("reset_out", 32'(out), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_zero", 32'(zero), 32'd1);
    reset = 1'b0;

    // IDLE: enable alone must not move the counter
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("idle_out_%0d", i), 32'(out), 32'd0);
      check($sformatf("idle_borrow_%0d", i), 32'(borrow_out), 32'd0);
      check($sformatf("idle_done_%0d", i), 32'(done), 32'd0);
    end

    // Load 3 then count five enabled edges, free-running
    en = 1'b0; load = 1'b1; load_val = 4'd3; oneshot = 1'b0;
    tick();
    check("load3_out", 32'(out), 32'd3);
    check("load3_zero", 32'(zero), 32'd0);
    load = 1'b0; en = 1'b1;
`ifdef AUTO_RELOAD_EN
    exp_seq = '{2, 1, 0, 3, 2};
`else
    exp_seq = '{2, 1, 0, 15, 14};
`endif
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("count_out_%0d", i), 32'(out), 32'(exp_seq[i]));
      check($sformatf("count_borrow_%0d", i), 32'(borrow_out), (exp_seq[i] == 0) ? 32'd1 : 32'd0);
    end

    // Borrow ripples through every bit: 1000 -> 0111
    en = 1'b0; load = 1'b1; load_val = 4'd8;
    tick();
    check("chain_load8", 32'(out), 32'd8);
    load = 1'b0; en = 1'b1;
    tick();
    check("chain_8_to_7", 32'(out), 32'd7);

    // Load has priority over enable
    en = 1'b0; load = 1'b1; load_val = 4'd9;
    tick();
    check("prio_load9", 32'(out), 32'd9);
    en = 1'b1; load_val = 4'd12;
    check("prio_no_borrow", 32'(borrow_out), 32'd0);
    tick();
    check("prio_out12", 32'(out), 32'd12);

    // One-shot: 2,1,0 then DONE and hold
    en = 1'b0; load = 1'b1; load_val = 4'd2; oneshot = 1'b1;
    tick();
    check("os_load2", 32'(out), 32'd2);
    load = 1'b0; en = 1'b1;
    tick();
    check("os_out1", 32'(out), 32'd1);
    tick();
    check("os_out0", 32'(out), 32'd0);
    check("os_done_before", 32'(done), 32'd0);
    check("os_borrow_at0", 32'(borrow_out), 32'd1);
    tick();
    check("os_done_set", 32'(done), 32'd1);
    check("os_done_out", 32'(out), 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("os_hold_done_%0d", i), 32'(done), 32'd1);
      check($sformatf("os_hold_out_%0d", i), 32'(out), 32'd0);
      check($sformatf("os_hold_borrow_%0d", i), 32'(borrow_out), 32'd0);
    end
    load = 1'b1; load_val = 4'd6;
    tick();
    check("os_reload_out", 32'(out), 32'd6);
    check("os_reload_done", 32'(done), 32'd0);

    // Load 0 with one-shot: DONE after exactly one enabled edge
    load_val = 4'd0; en = 1'b0;
    tick();
    check("os0_out", 32'(out), 32'd0);
    check("os0_done_pre", 32'(done), 32'd0);
    load = 1'b0; en = 1'b1;
    tick();
    check("os0_done", 32'(done), 32'd1);
    check("os0_out_hold", 32'(out), 32'd0);

    // Asynchronous reset mid-count at out=5
    en = 1'b0; load = 1'b1; load_val = 4'd5; oneshot = 1'b0;
    tick();
    check("rst_pre_out", 32'(out), 32'd5);
    load = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_async_out", 32'(out), 32'd0);
    check("rst_async_done", 32'(done), 32'd0);
    tick();
    reset = 1'b0;
    en = 1'b1;
    tick();
    check("rst_idle_out", 32'(out), 32'd0);
    check("rst_idle_borrow", 32'(borrow_out), 32'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule

// File: doc/serial_borrow_down_counter.md
Name: serial_borrow_down_counter

Overview:
Parameterised down counter built from a serial borrow chain of toggle stages. It is the counting-down counterpart to the team's serial-carry up counter. It provides parallel load, count enable, zero detect and a borrow-out for cascading, with free-running or one-shot operation. It is used as a programmable delay/divider in the same sequential-circuits library and shares the same clocking: falling edge of clk, asynchronous reset.

Parameters:
- WIDTH, 4, counter width in bits (≥2).

Ports:
- clk  input  1  counter clock; all state updates on negedge clk.
- reset  input  1  reset, asynchronous, active-high.
- en  input  1  count enable; sampled at negedge clk.
- load  input  1  parallel load request; sampled at negedge clk.
- load_val  input  WIDTH  value loaded when load=1.
- oneshot  input  1  1 = stop at zero; 0 = free-run/wrap.
- out  output  WIDTH  current count.
- zero  output  1  combinational, 1 when out==0.
- borrow_out  output  1  combinational, en & zero & ~load & (state==RUN); cascade enable for the next stage.
- done  output  1  registered; 1 while in DONE state.

Behaviour:
- Reset (async, active-high, overrides everything):
  - out=0, state=IDLE, done=0.
  - Outputs are held while reset=1.
  - Deassertion takes effect at the next negedge.
- Toggle structure: bit i toggles when T_i = count_step & (out[i-1:0]==0). Bit 0 has T_0 = count_step. Implementation uses one toggle stage per bit with this borrow chain; no adder.
- count_step = en & ~load & (state==RUN).
- FSM states: IDLE, RUN, DONE.
  - IDLE: counter holds. load=1 → out=load_val, state=RUN. en alone has no effect.
  - RUN:
    - load=1 → reload load_val, stay RUN (load has priority over en).
    - en=1 & out!=0 → out-1.
    - en=1 & out==0 & oneshot=0 → out wraps to 2^WIDTH-1, stay RUN.
    - en=1 & out==0 & oneshot=1 → out stays 0, state=DONE, done=1 from the same edge.
  - DONE: holds out=0, done=1. load=1 → out=load_val, state=RUN, done=0 at that edge. en ignored.
- Latency: out changes at the negedge where the qualifying input is sampled; zero and borrow_out follow combinationally.
- Load of 0 in RUN with oneshot=1 and en=1 on the next edge → DONE after exactly 1 enabled edge.
- oneshot changed mid-count: takes effect at the next edge where out==0.
- Reset asserted mid-count or in DONE: immediate return to out=0, IDLE.

Optional Feature:
Macro AUTO_RELOAD_EN.
- Defined: in RUN with en=1 & out==0 & oneshot=0, out reloads load_val instead of wrapping to all-ones. The counter becomes a divide-by-(load_val+1) divider. borrow_out still pulses on that edge.
- Not defined: wrap to 2^WIDTH-1 as above.
- oneshot=1 behaviour is identical in both builds.

Test Plan:
1. Reset: assert reset mid-count at out=5 (WIDTH=4) → out=0, done=0, state IDLE immediately, without waiting for a clock edge.
2. Load then count: load=1, load_val=3, then en=1 for 5 negedges, oneshot=0.
   - Default build → out 3,2,1,0,15,14; borrow_out=1 only during the cycle out=0.
   - AUTO_RELOAD_EN build → out 3,2,1,0,3,2.
3. One-shot: load_val=2, oneshot=1, en=1 → out 2,1,0 then DONE. done=1 and out holds 0 for 10 further edges. A later load_val=6 → out=6, done=0.
4. Priority: in RUN at out=9, load=1, en=1, load_val=12 on the same edge → out=12, no decrement.
5. Borrow chain: load_val=8 (1000), en=1 → next out=7 (0111). All four bits toggle on one edge.
6. IDLE hold: after reset, en=1 for 4 edges with no load → out stays 0, borrow_out=0, done=0.
